// File: rtl/combination_store_if.sv
// Keypad/lock-FSM side of the combination store: digit strobes, commit strobes and match status.
// Strobes are single-cycle with no ready; the store accepts every cycle.
interface combination_store_if #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4
);
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic [DIGIT_W-1:0] Digit;
    logic               DigitValid;
    logic               Clear;
    logic               Enter;
    logic               Change;
    logic               New;
    logic               isCorrect;
    logic [CNT_W-1:0]   EntryCount;
    logic               EntryFull;

    modport master (
        output Digit, DigitValid, Clear, Enter, Change, New,
        input  isCorrect, EntryCount, EntryFull
    );

    modport slave (
        input  Digit, DigitValid, Clear, Enter, Change, New,
        output isCorrect, EntryCount, EntryFull
    );
endinterface

// File: rtl/combination_store.sv
// Lock code + keyed-entry buffer; isCorrect is 0-cycle from registers, updates land next edge.
// No backpressure: digits beyond a full buffer are dropped. ENTRY_TIMEOUT_EN adds an idle flush.
module combination_store #(
    parameter int                              DIGIT_W        = 4,
    parameter int                              NUM_DIGITS     = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0]   DEFAULT_CODE   = 16'h1234
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int                              TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic                Clock,
    input  logic                Resetn,
    combination_store_if.slave  bus
);
    localparam int CODE_W = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);

    logic [CODE_W-1:0] code_q,  code_d;
    logic [CODE_W-1:0] entry_q, entry_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              entry_full;
    logic              any_strobe;
    logic              timeout_hit;

    assign entry_full = (count_q == CNT_W'(NUM_DIGITS));
    assign any_strobe = bus.DigitValid | bus.Clear | bus.Enter | bus.Change;

`ifdef ENTRY_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    assign timeout_hit = (count_q != '0) && (idle_q == IDLE_LAST);

    always_comb begin
        idle_d = idle_q;
        if (any_strobe || timeout_hit) begin
            idle_d = '0;
        end else if ((count_q != '0) && (idle_q != IDLE_LAST)) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Clear beats Enter/Change beats a digit; the commit uses the pre-edge entry.
    always_comb begin
        code_d  = code_q;
        entry_d = entry_q;
        count_d = count_q;
        if (bus.Clear) begin
            entry_d = '0;
            count_d = '0;
        end else if (bus.Enter || bus.Change) begin
            if (bus.New && bus.Enter && entry_full) begin
                code_d = entry_q;
            end
            entry_d = '0;
            count_d = '0;
        end else if (bus.DigitValid) begin
            if (!entry_full) begin
                entry_d = (entry_q << DIGIT_W) | CODE_W'(bus.Digit);
                count_d = count_q + CNT_W'(1);
            end
        end else if (timeout_hit) begin
            entry_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            code_q  <= DEFAULT_CODE;
            entry_q <= '0;
            count_q <= '0;
        end else begin
            code_q  <= code_d;
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign bus.isCorrect  = entry_full && (entry_q == code_q);
    assign bus.EntryCount = count_q;
    assign bus.EntryFull  = entry_full;
endmodule

// File: tb/tb_combination_store.sv
// Directed checks of entry buffering, matching, code commit/abort, strobe priority and reset.
module tb_combination_store;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    combination_store_if #(.DIGIT_W(4), .NUM_DIGITS(4)) bus ();

`ifdef ENTRY_TIMEOUT_EN
    combination_store #(.DIGIT_W(4), .NUM_DIGITS(4), .DEFAULT_CODE(16'h1234),
                        .TIMEOUT_CYCLES(8)) dut (
        .Clock(clk), .Resetn(rst_n), .bus(bus)
    );
`else
    combination_store #(.DIGIT_W(4), .NUM_DIGITS(4), .DEFAULT_CODE(16'h1234)) dut (
        .Clock(clk), .Resetn(rst_n), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Strobes are set at a falling edge, captured on the rising edge, dropped at the next fall.
    task automatic pulse(input logic dv, input logic clr, input logic ent,
                         input logic chg, input logic [3:0] d);
        @(negedge clk);
        bus.Digit      = d;
        bus.DigitValid = dv;
        bus.Clear      = clr;
        bus.Enter      = ent;
        bus.Change     = chg;
        @(negedge clk);
        bus.DigitValid = 1'b0;
        bus.Clear      = 1'b0;
        bus.Enter      = 1'b0;
        bus.Change     = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic key4(input logic [15:0] c);
        key(c[15:12]);
        key(c[11:8]);
        key(c[7:4]);
        key(c[3:0]);
    endtask

    task automatic clear_entry();
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        bus.Digit      = '0;
        bus.DigitValid = 1'b0;
        bus.Clear      = 1'b0;
        bus.Enter      = 1'b0;
        bus.Change     = 1'b0;
        bus.New        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_count", int'(bus.EntryCount), 0);
        check("rst_full",  int'(bus.EntryFull), 0);
        check("rst_correct", int'(bus.isCorrect), 0);
        rst_n = 1'b1;

        // 1: default code matches, count steps 1..4, Enter empties
        key(4'h1); check("t1_cnt1", int'(bus.EntryCount), 1);
        check("t1_partial_correct", int'(bus.isCorrect), 0);
        key(4'h2); check("t1_cnt2", int'(bus.EntryCount), 2);
        key(4'h3); check("t1_cnt3", int'(bus.EntryCount), 3);
        check("t1_full3", int'(bus.EntryFull), 0);
        key(4'h4); check("t1_cnt4", int'(bus.EntryCount), 4);
        check("t1_full", int'(bus.EntryFull), 1);
        check("t1_correct", int'(bus.isCorrect), 1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        check("t1_enter_cnt", int'(bus.EntryCount), 0);
        check("t1_enter_correct", int'(bus.isCorrect), 0);

        // 2: wrong code, fifth digit dropped
        key4(16'h1235);
        check("t2_full", int'(bus.EntryFull), 1);
        check("t2_correct", int'(bus.isCorrect), 0);
        key(4'h9);
        check("t2_overflow_cnt", int'(bus.EntryCount), 4);
        check("t2_overflow_correct", int'(bus.isCorrect), 0);
        clear_entry();
        check("t2_clear_cnt", int'(bus.EntryCount), 0);

        // Enter with New=0 earlier must not have written the code
        key4(16'h1234);
        check("t1_no_write", int'(bus.isCorrect), 1);
        clear_entry();

        // 4: short commit rejected, Change aborts
        bus.New = 1'b1;
        key(4'h5); key(4'h5);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        check("t4_short_cnt", int'(bus.EntryCount), 0);
        bus.New = 1'b0;
        key4(16'h1234);
        check("t4_short_keep", int'(bus.isCorrect), 1);
        clear_entry();
        bus.New = 1'b1;
        key4(16'h4321);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("t4_abort_cnt", int'(bus.EntryCount), 0);
        bus.New = 1'b0;
        key4(16'h4321);
        check("t4_abort_new", int'(bus.isCorrect), 0);
        clear_entry();
        key4(16'h1234);
        check("t4_abort_keep", int'(bus.isCorrect), 1);
        clear_entry();

        // 5: DigitValid+Clear+Enter together: Clear wins, no commit, digit dropped
        bus.New = 1'b1;
        key4(16'h4321);
        pulse(1'b1, 1'b1, 1'b1, 1'b0, 4'h7);
        check("t5_cnt", int'(bus.EntryCount), 0);
        bus.New = 1'b0;
        key4(16'h1234);
        check("t5_keep", int'(bus.isCorrect), 1);
        clear_entry();

        // 3: commit 9876
        bus.New = 1'b1;
        key4(16'h9876);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        bus.New = 1'b0;
        key4(16'h1234);
        check("t3_old_code", int'(bus.isCorrect), 0);
        clear_entry();
        key4(16'h9876);
        check("t3_new_code", int'(bus.isCorrect), 1);
        clear_entry();

        // 6: async reset mid-entry restores default code
        key(4'h9); key(4'h8);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("t6_async_cnt", int'(bus.EntryCount), 0);
        @(negedge clk);
        rst_n = 1'b1;
        key4(16'h9876);
        check("t6_old_gone", int'(bus.isCorrect), 0);
        clear_entry();
        key4(16'h1234);
        check("t6_default", int'(bus.isCorrect), 1);
        clear_entry();

        // Enter and Change together commit like Enter
        bus.New = 1'b1;
        key4(16'h5678);
        pulse(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
        bus.New = 1'b0;
        key4(16'h5678);
        check("both_commit", int'(bus.isCorrect), 1);
        clear_entry();

        // Idle partial entry: flushed after 8 cycles with the timeout, held without it
        key(4'h1);
        check("idle_cnt_start", int'(bus.EntryCount), 1);
        repeat (7) @(negedge clk);
        check("idle_cnt_7", int'(bus.EntryCount), 1);
        @(negedge clk);
`ifdef ENTRY_TIMEOUT_EN
        check("idle_flush", int'(bus.EntryCount), 0);
`else
        repeat (20) @(negedge clk);
        check("idle_hold", int'(bus.EntryCount), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
